// File: rtl/port_rd_dispatch_if.sv
// Read-dispatch bus between a port reader and its priority dispatcher.
// The reader side (master) drives mode, occupancy and consume pulses; the dispatcher answers.
interface port_rd_dispatch_if #(
  parameter int unsigned QUEUE_NUM = 4,
  parameter int unsigned PRIOR_W   = 2
);
  logic                 wrr_en;
  logic [QUEUE_NUM-1:0] queue_empty;
  logic                 prior_update;
  logic [PRIOR_W-1:0]   prior_next;

  modport master (
    output wrr_en,
    output queue_empty,
    output prior_update,
    input  prior_next
  );

  modport slave (
    input  wrr_en,
    input  queue_empty,
    input  prior_update,
    output prior_next
  );
endinterface

// File: rtl/port_rd_dispatch.sv
// Read-side queue selector for one output port: strict priority or credit-based
// weighted round robin, with the chosen queue presented as a registered index.
module port_rd_dispatch #(
  parameter int unsigned QUEUE_NUM = 4,
  parameter int unsigned PRIOR_W   = 2
) (
  input logic               clk,
  input logic               rst_n,
  port_rd_dispatch_if.slave rd_if
);

  localparam int unsigned CredW = $clog2(QUEUE_NUM + 1);
  typedef logic [CredW-1:0] cred_t;

  cred_t              credit_q [QUEUE_NUM];
  cred_t              credit_d [QUEUE_NUM];
  cred_t              cred_dec [QUEUE_NUM];
  logic [PRIOR_W-1:0] prior_q, prior_d;
  logic [PRIOR_W-1:0] idx;
  logic               stay, hit, any_ready;

  // Queue i earns QUEUE_NUM-i reads per round.
  function automatic cred_t weight(int unsigned i);
    return cred_t'(QUEUE_NUM - i);
  endfunction

  always_comb begin
    prior_d   = prior_q;
    credit_d  = credit_q;
    cred_dec  = credit_q;
    stay      = 1'b0;
    hit       = 1'b0;
    idx       = '0;
    any_ready = ~&rd_if.queue_empty;

    if (!rd_if.wrr_en) begin
      for (int unsigned i = 0; i < QUEUE_NUM; i++) credit_d[i] = weight(i);
      // Walk downwards so the lowest non-empty index wins; all-empty holds.
      for (int i = int'(QUEUE_NUM) - 1; i >= 0; i--) begin
        if (!rd_if.queue_empty[i]) prior_d = PRIOR_W'(i);
      end
    end else begin
      if (rd_if.prior_update && cred_dec[prior_q] != '0) begin
        cred_dec[prior_q] = cred_dec[prior_q] - cred_t'(1);
      end
      stay     = !rd_if.queue_empty[prior_q] &&
                 (!rd_if.prior_update || cred_dec[prior_q] != '0);
      credit_d = cred_dec;

      if (!stay) begin
        for (int unsigned k = 1; k <= QUEUE_NUM; k++) begin
          idx = PRIOR_W'((32'(prior_q) + k) % QUEUE_NUM);
          if (!hit && !rd_if.queue_empty[idx] && cred_dec[idx] != '0) begin
            hit     = 1'b1;
            prior_d = idx;
          end
        end
        // Round exhausted: start a fresh round, discarding this cycle's decrement.
        if (!hit && any_ready) begin
          for (int unsigned i = 0; i < QUEUE_NUM; i++) credit_d[i] = weight(i);
          for (int unsigned k = 1; k <= QUEUE_NUM; k++) begin
            idx = PRIOR_W'((32'(prior_q) + k) % QUEUE_NUM);
            if (!hit && !rd_if.queue_empty[idx]) begin
              hit     = 1'b1;
              prior_d = idx;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prior_q <= '0;
      for (int unsigned i = 0; i < QUEUE_NUM; i++) credit_q[i] <= weight(i);
    end else begin
      prior_q  <= prior_d;
      credit_q <= credit_d;
    end
  end

  assign rd_if.prior_next = prior_q;

endmodule

// File: tb/tb_port_rd_dispatch.sv
// Directed bench for port_rd_dispatch: a queue-level reference model checked every
// cycle, plus literal sequences taken straight from the intended behaviour.
module tb_port_rd_dispatch;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  port_rd_dispatch_if #(.QUEUE_NUM(4), .PRIOR_W(2)) bus ();

  port_rd_dispatch #(.QUEUE_NUM(4), .PRIOR_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rd_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      prior;
    logic [3:0][3:0] cred;
  } mst_t;

  mst_t m_st;
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic mst_t model_next(mst_t s, logic wrr, logic [3:0] qe, logic upd);
    mst_t n   = s;
    int   cur = int'(s.prior);
    int   j;
    bit   got = 1'b0;
    if (!wrr) begin
      for (int i = 0; i < 4; i++) n.cred[i] = 4'(4 - i);
      for (int i = 3; i >= 0; i--) if (!qe[i]) n.prior = 2'(i);
      return n;
    end
    if (upd && n.cred[cur] > 0) n.cred[cur] = n.cred[cur] - 4'd1;
    if (!qe[cur] && (!upd || n.cred[cur] > 0)) return n;
    for (int k = 1; k <= 4; k++) begin
      j = (cur + k) % 4;
      if (!got && !qe[j] && n.cred[j] > 0) begin
        n.prior = 2'(j);
        got     = 1'b1;
      end
    end
    if (!got && qe != 4'hf) begin
      for (int i = 0; i < 4; i++) n.cred[i] = 4'(4 - i);
      for (int k = 1; k <= 4; k++) begin
        j = (cur + k) % 4;
        if (!got && !qe[j]) begin
          n.prior = 2'(j);
          got     = 1'b1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_st <= {2'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    else        m_st <= model_next(m_st, bus.wrr_en, bus.queue_empty, bus.prior_update);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: prior_next=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model", int'(bus.prior_next), int'(m_st.prior));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset(input logic wrr, input logic [3:0] qe, input logic upd);
    rst_n            = 1'b0;
    bus.wrr_en       = wrr;
    bus.queue_empty  = qe;
    bus.prior_update = upd;
    tick();
    chk("in_reset", int'(bus.prior_next), 0);
    rst_n = 1'b1;
  endtask

  int seq3 [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
  int seq4 [7]  = '{0, 0, 0, 0, 2, 2, 3};
  int seq5 [8]  = '{1, 1, 2, 2, 3, 0, 0, 1};
  int vis6 [5]  = '{0, 2, 3, 3, 3};
  int cnt  [4];
  int consumed;

  initial begin
    bus.wrr_en       = 1'b0;
    bus.queue_empty  = 4'hf;
    bus.prior_update = 1'b0;
    @(negedge clk);
    chk("reset_value", int'(bus.prior_next), 0);

    // Idle after release, all queues empty.
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_hold", int'(bus.prior_next), 0);
    end

    // Strict priority; update pulses ignored.
    bus.queue_empty  = 4'b0101;
    bus.prior_update = 1'b1;
    tick();
    chk("strict_0101", int'(bus.prior_next), 1);
    bus.queue_empty = 4'b1100;
    tick();
    chk("strict_1100", int'(bus.prior_next), 0);
    bus.queue_empty = 4'b0001;
    tick();
    chk("strict_0001", int'(bus.prior_next), 1);
    bus.prior_update = 1'b0;
    tick();
    chk("strict_noupd", int'(bus.prior_next), 1);

    // WRR, all queues busy, continuous consume.
    do_reset(1'b1, 4'b0000, 1'b1);
    chk("wrr_all_0", int'(bus.prior_next), seq3[0]);
    for (int i = 1; i < 20; i++) begin
      tick();
      chk("wrr_all", int'(bus.prior_next), seq3[i % 10]);
    end

    // WRR with queue 1 empty.
    do_reset(1'b1, 4'b0010, 1'b1);
    chk("wrr_skip1_0", int'(bus.prior_next), seq4[0]);
    for (int i = 1; i < 14; i++) begin
      tick();
      chk("wrr_skip1", int'(bus.prior_next), seq4[i % 7]);
    end

    // Leftover credit on queue 0 survives a switch-away and is spent later.
    do_reset(1'b1, 4'b0000, 1'b1);
    tick();
    tick();
    chk("credit_setup", int'(bus.prior_next), 0);
    bus.prior_update = 1'b0;
    bus.queue_empty  = 4'b0001;
    tick();
    chk("empty_switch", int'(bus.prior_next), 1);
    bus.queue_empty  = 4'b0000;
    bus.prior_update = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("leftover_credit", int'(bus.prior_next), seq5[i]);
    end

    // Sparse consumption driven from per-queue packet counts.
    cnt = '{1, 0, 1, 3};
    do_reset(1'b1, 4'b1111, 1'b0);
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 15; c++) begin
        for (int q = 0; q < 4; q++) bus.queue_empty[q] = (cnt[q] == 0);
        bus.prior_update = 1'b0;
        tick();
      end
      consumed = int'(bus.prior_next);
      chk("visit", consumed, vis6[p]);
      bus.prior_update = 1'b1;
      tick();
      if (cnt[consumed] > 0) cnt[consumed]--;
    end
    bus.prior_update = 1'b0;
    for (int c = 0; c < 15; c++) begin
      for (int q = 0; q < 4; q++) bus.queue_empty[q] = (cnt[q] == 0);
      tick();
    end
    chk("hold_empty", int'(bus.prior_next), 3);

    // Asynchronous reset mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", int'(bus.prior_next), 0);
    cmp_model();
    #5;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
